// File: rtl/iterative_roll_right.sv
// -----------------------------------------------------------------------------
// iterative_roll_right
//
// Multi-cycle rotate-right engine with valid/ready handshakes on both sides.
// A word and a shift amount are accepted in IDLE. The word is rotated right
// one position per cycle in ROLL, or four positions per cycle while at least
// four remain when ROLL_BY4_EN is defined. The finished word is then held in
// HOLD until the downstream stage takes it.
//
// Optional feature macro: ROLL_BY4_EN (adds the rotate-by-4 fast step).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   inData/shamt valid
//   in_ready   engine can accept a word (IDLE), registered
//   inData     word to rotate
//   shamt      rotate-right amount, 0..WIDTH-1
//   out_valid  outData holds a finished result (HOLD), registered
//   out_ready  downstream accepts outData
//   outData    rotated word, registered; keeps its last value in IDLE
//   busy       high in ROLL or HOLD, registered
// -----------------------------------------------------------------------------
module iterative_roll_right #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   inData,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   outData,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   data_r;
  logic [SHAMT_W-1:0] count;

  // One rotation step: the data and remaining count after this cycle.
  logic [WIDTH-1:0]   step_data;
  logic [SHAMT_W-1:0] step_count;

  always_comb begin
    step_data  = {data_r[0], data_r[WIDTH-1:1]};
    step_count = count - SHAMT_W'(1);
`ifdef ROLL_BY4_EN
    if (count >= SHAMT_W'(4)) begin
      step_data  = {data_r[3:0], data_r[WIDTH-1:4]};
      step_count = count - SHAMT_W'(4);
    end
`endif
  end

  // The handshake flags are registered alongside the state so they change
  // exactly on the edge that changes state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_r    <= '0;
      count     <= '0;
      outData   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_r   <= inData;
            count    <= shamt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (shamt == '0) begin
              // Nothing to rotate: the input is the result.
              state     <= HOLD;
              outData   <= inData;
              out_valid <= 1'b1;
            end else begin
              state <= ROLL;
            end
          end
        end

        ROLL: begin
          data_r <= step_data;
          count  <= step_count;
          // Leave on the step that exhausts the count, so count never wraps.
          if (step_count == '0) begin
            state     <= HOLD;
            outData   <= step_data;
            out_valid <= 1'b1;
          end
        end

        HOLD: begin
          // in_ready rises only after this edge, so a word cannot be taken
          // in the same cycle as the output handshake.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
